// File: rtl/vector_store_unit.sv
// vector_store_unit
//   Writeback stage behind the 4x4 matrix/dot-product datapath. Accepts one
//   packed WIDTH_V-bit vector plus a base byte address, then writes it
//   element by element (element 0 = MSB slice) into byte-wide data memory at
//   base, base+1, ... (address wraps silently). Pulses done_o once the last
//   element has been committed.
//
//   Optional feature macro: STORE_MASK_EN
//     When defined, adds in_mask_i; bit i enables the write of element i.
//     A masked-off element still occupies its address slot and its WRITE
//     cycle (mem_we_o=0), and advances in one cycle regardless of mem_ready_i.
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset; forces all outputs to 0
//   in_valid_i   in_data_i/in_addr_i valid
//   in_ready_o   unit idle and able to accept a vector
//   in_data_i    packed vector, element 0 at [WIDTH_V-1 -: BITS_INDEX]
//   in_addr_i    byte address of element 0
//   in_mask_i    (STORE_MASK_EN) per-element write enable
//   mem_we_o     memory write strobe
//   mem_addr_o   memory write address
//   mem_wdata_o  memory write data
//   mem_ready_i  memory accepts the write this cycle
//   busy_o       store in progress
//   done_o       one-cycle pulse, vector fully stored
module vector_store_unit #(
  parameter int WIDTH_V    = 128,
  parameter int BITS_INDEX = 8,
  parameter int ADDR_W     = 32
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            in_valid_i,
  output logic                            in_ready_o,
  input  logic [WIDTH_V-1:0]              in_data_i,
  input  logic [ADDR_W-1:0]               in_addr_i,
`ifdef STORE_MASK_EN
  input  logic [WIDTH_V/BITS_INDEX-1:0]   in_mask_i,
`endif
  output logic                            mem_we_o,
  output logic [ADDR_W-1:0]               mem_addr_o,
  output logic [BITS_INDEX-1:0]           mem_wdata_o,
  input  logic                            mem_ready_i,
  output logic                            busy_o,
  output logic                            done_o
);
  localparam int NUM_ELEMENTS = WIDTH_V / BITS_INDEX;
  localparam int IDX_W        = $clog2(NUM_ELEMENTS);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [WIDTH_V-1:0]    data_q, data_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
`ifdef STORE_MASK_EN
  logic [NUM_ELEMENTS-1:0] mask_q, mask_d;
`endif

  logic                  cur_en;
  logic                  advance;
  logic                  last;
  logic [BITS_INDEX-1:0] elem;

`ifdef STORE_MASK_EN
  assign cur_en = mask_q[idx_q];
`else
  assign cur_en = 1'b1;
`endif

  assign elem    = data_q[WIDTH_V-1 - int'(idx_q)*BITS_INDEX -: BITS_INDEX];
  assign last    = (idx_q == IDX_W'(NUM_ELEMENTS-1));
  // A masked-off element never waits on memory: it only burns its slot.
  assign advance = (state_q == S_WRITE) && (mem_ready_i || !cur_en);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    addr_d  = addr_q;
`ifdef STORE_MASK_EN
    mask_d  = mask_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid_i) begin
          data_d  = in_data_i;
          addr_d  = in_addr_i;
`ifdef STORE_MASK_EN
          mask_d  = in_mask_i;
`endif
          idx_d   = '0;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (advance) begin
          idx_d = idx_q + 1'b1;
          if (last) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      addr_q  <= '0;
`ifdef STORE_MASK_EN
      mask_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
`ifdef STORE_MASK_EN
      mask_q  <= mask_d;
`endif
    end
  end

  // Outputs decode registered state only; rst_i masks them so that nothing
  // is strobed during the reset cycle even if a store was in flight.
  assign in_ready_o  = !rst_i && (state_q == S_IDLE);
  assign busy_o      = !rst_i && (state_q != S_IDLE);
  assign done_o      = !rst_i && (state_q == S_DONE);
  assign mem_we_o    = !rst_i && (state_q == S_WRITE) && cur_en;
  assign mem_addr_o  = rst_i ? '0 : addr_q + ADDR_W'(idx_q);
  assign mem_wdata_o = rst_i ? '0 : elem;

endmodule
